// File: rtl/gate_exhaustive_checker_if.sv
// Signal bundle between the exhaustive checker and the environment around the cell under test.
// START is a level sampled only while the checker is idle; DONE is a one-cycle pulse after the last sample.
interface gate_exhaustive_checker_if #(
   parameter int N_IN = 4
);
   logic            START;
   logic            ZN;
   logic [N_IN-1:0] A;
   logic            BUSY;
   logic            DONE;
   logic            PASS;
   logic [N_IN:0]   ERR_CNT;
   logic [N_IN-1:0] FIRST_FAIL;
   logic            FAIL_VLD;

   modport master (
      input  START, ZN,
      output A, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_VLD
   );

   modport slave (
      output START, ZN,
      input  A, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_VLD
   );
endinterface

// File: rtl/gate_exhaustive_checker.sv
// Walks every input pattern of an N_IN-input cell, holds each for a settle window,
// then compares the cell output against EXP_TT and reports count, first failure and pass.
module gate_exhaustive_checker #(
   parameter int                     N_IN       = 4,
   parameter logic [(1<<N_IN)-1:0]   EXP_TT     = 16'h8000,
   parameter int                     SETTLE_CYC = 2
) (
   input  logic                        CK,
   input  logic                        RN,
   gate_exhaustive_checker_if.master   bus,
   output logic [1:0]                  state_o
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [N_IN-1:0] PAT_ONE  = N_IN'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      FIN    = 2'd3
   } state_t;

   state_t          state_q;
   logic [N_IN-1:0] pat_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic [N_IN:0]   err_q;
   logic [N_IN:0]   err_d;
   logic [N_IN-1:0] first_q;
   logic            fvld_q;
   logic            mismatch;

   // Case inequality so an X or Z response from the cell is flagged as a failure.
   always_comb begin
      mismatch = 1'b0;
      err_d    = err_q;
      mismatch = (bus.ZN !== EXP_TT[pat_q]);
      err_d    = err_q + (N_IN+1)'(mismatch);
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         pat_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         first_q <= '0;
         fvld_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.START) begin
                  state_q <= SETTLE;
                  pat_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  first_q <= '0;
                  fvld_q  <= 1'b0;
               end
            end
            SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= SAMPLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            SAMPLE: begin
               err_q <= err_d;
               if (mismatch && !fvld_q) begin
                  first_q <= pat_q;
                  fvld_q  <= 1'b1;
               end
               // The increment wraps to zero after the last pattern, leaving A idle at 0.
               pat_q <= pat_q + PAT_ONE;
               cnt_q <= '0;
               if (&pat_q) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  pass_q  <= (err_d == '0);
               end else begin
                  state_q <= SETTLE;
               end
            end
            FIN: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.A          = pat_q;
   assign bus.BUSY       = busy_q;
   assign bus.DONE       = done_q;
   assign bus.PASS       = pass_q;
   assign bus.ERR_CNT    = err_q;
   assign bus.FIRST_FAIL = first_q;
   assign bus.FAIL_VLD   = fvld_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Bench for gate_exhaustive_checker: two instances (default AND4 and a 1-cycle-settle NAND4),
// a truth-table model of the cell under test, and result prediction by popcount over differences.
module tb_gate_exhaustive_checker;

   logic        CK;
   logic        RN;
   logic        start;
   logic        sel;
   logic [15:0] cell_tt;

   gate_exhaustive_checker_if #(.N_IN(4)) if0 ();
   gate_exhaustive_checker_if #(.N_IN(4)) if1 ();
   logic [1:0] st0, st1;

   gate_exhaustive_checker #(.N_IN(4), .EXP_TT(16'h8000), .SETTLE_CYC(2)) dut0 (
      .CK(CK), .RN(RN), .bus(if0.master), .state_o(st0));
   gate_exhaustive_checker #(.N_IN(4), .EXP_TT(16'h7FFF), .SETTLE_CYC(1)) dut1 (
      .CK(CK), .RN(RN), .bus(if1.master), .state_o(st1));

   // Cell under test modelled as a truth table indexed by the applied pattern.
   assign if0.START = start & ~sel;
   assign if1.START = start & sel;
   assign if0.ZN    = cell_tt[if0.A];
   assign if1.ZN    = cell_tt[if1.A];

   logic [3:0] a_m, ff_m;
   logic [4:0] err_m;
   logic       busy_m, done_m, pass_m, fv_m;
   logic [1:0] st_m;
   assign a_m    = sel ? if1.A          : if0.A;
   assign busy_m = sel ? if1.BUSY       : if0.BUSY;
   assign done_m = sel ? if1.DONE       : if0.DONE;
   assign pass_m = sel ? if1.PASS       : if0.PASS;
   assign err_m  = sel ? if1.ERR_CNT    : if0.ERR_CNT;
   assign ff_m   = sel ? if1.FIRST_FAIL : if0.FIRST_FAIL;
   assign fv_m   = sel ? if1.FAIL_VLD   : if0.FAIL_VLD;
   assign st_m   = sel ? st1            : st0;

   // Clock / reset
   initial CK = 1'b0;
   always #5 CK = ~CK;

   int total_cnt = 0;
   int bad_cnt   = 0;
   logic [10:0] exp_q[$];   // {err[4:0], first[3:0], fvld, pass}

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   // Reference: result is a pure function of the cell table versus the expected table.
   function automatic logic [10:0] model(input logic [15:0] tt, input logic [15:0] exp_tt);
      logic [15:0] diff;
      int          n;
      int          first;
      diff  = tt ^ exp_tt;
      n     = $countones(diff);
      first = 0;
      for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
      return {5'(n), 4'(first), (diff != 0), (diff == 0)};
   endfunction

   task automatic check_all_zero(input string nm);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #0;
         check($sformatf("%s_s%0d_outs", nm, s),
               {28'd0, a_m, busy_m, done_m, pass_m, err_m, ff_m, fv_m, st_m}, 32'd0);
      end
      sel = 1'b0;
   endtask

   // Drive one full run and check the pattern walk, busy/done timing and final result.
   task automatic run(input logic s, input logic [15:0] tt, input logic [10:0] expv, input string nm);
      int          p, tot, seq_bad, seq_e;
      logic [3:0]  exp_a;
      logic        exp_busy, exp_done, seen;
      logic [10:0] e_rec;
      sel = s; cell_tt = tt;
      exp_q.push_back(expv);
      p = s ? 2 : 3;
      tot = 16 * p;
      seq_bad = 0; seq_e = -1; seen = 1'b0; e_rec = expv;
      @(negedge CK); start = 1'b1;
      @(posedge CK);
      for (int e = 0; e <= tot + 3; e++) begin
         if (e > 0) @(posedge CK);
         @(negedge CK);
         if (e == 0) start = 1'b0;
         exp_a    = (e < tot) ? 4'(e / p) : 4'd0;
         exp_busy = (e < tot);
         exp_done = (e == tot);
         if (a_m !== exp_a || busy_m !== exp_busy || done_m !== exp_done) begin
            if (seq_bad == 0) seq_e = e;
            seq_bad++;
         end
         if (done_m === 1'b1 && !seen && exp_q.size() > 0) begin
            seen  = 1'b1;
            e_rec = exp_q.pop_front();
            check({nm, "_err_cnt"},    {27'd0, err_m}, {27'd0, e_rec[10:6]});
            check({nm, "_first_fail"}, {28'd0, ff_m},  {28'd0, e_rec[5:2]});
            check({nm, "_fail_vld"},   {31'd0, fv_m},  {31'd0, e_rec[1]});
            check({nm, "_pass"},       {31'd0, pass_m},{31'd0, e_rec[0]});
         end
      end
      if (seq_bad != 0) $display("  %s: first sequence deviation after edge %0d", nm, seq_e);
      check({nm, "_seq_deviations"}, seq_bad, 0);
      check({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
      check({nm, "_pass_held"}, {31'd0, pass_m}, {31'd0, e_rec[0]});
   endtask

   typedef struct {
      logic        s;
      logic [15:0] tt;
      logic [4:0]  err;
      logic [3:0]  first;
      logic        fv;
      logic        pass;
      string       nm;
   } vec_t;

   vec_t vecs[7];
   int   n_ok, n_done;
   logic found;

   initial begin
      vecs[0] = '{1'b0, 16'h8000, 5'd0,  4'd0,  1'b0, 1'b1, "and4_good"};
      vecs[1] = '{1'b0, 16'hFFFF, 5'd15, 4'd0,  1'b1, 1'b0, "zn_stuck1"};
      vecs[2] = '{1'b0, 16'h0000, 5'd1,  4'd15, 1'b1, 1'b0, "zn_stuck0"};
      vecs[3] = '{1'b0, 16'h7FFF, 5'd16, 4'd0,  1'b1, 1'b0, "all_wrong"};
      vecs[4] = '{1'b0, 16'h8020, 5'd1,  4'd5,  1'b1, 1'b0, "flip_p5"};
      vecs[5] = '{1'b1, 16'h7FFF, 5'd0,  4'd0,  1'b0, 1'b1, "nand4_good"};
      vecs[6] = '{1'b1, 16'h7DFF, 5'd1,  4'd9,  1'b1, 1'b0, "nand4_flip9"};

      RN = 1'b1; start = 1'b0; sel = 1'b0; cell_tt = 16'h8000;
      // Reset asserted between edges must clear outputs without a clock.
      #3 RN = 1'b0;
      #1 check_all_zero("async_reset");
      repeat (2) @(negedge CK);
      RN = 1'b1;
      n_ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CK);
         if (busy_m === 1'b0 && done_m === 1'b0 && a_m === 4'd0 && st_m === 2'd0) n_ok++;
      end
      check("idle_after_reset", n_ok, 10);

      for (int i = 0; i < 7; i++)
         run(vecs[i].s, vecs[i].tt,
             {vecs[i].err, vecs[i].first, vecs[i].fv, vecs[i].pass}, vecs[i].nm);

      // START held high: exactly one DONE, FIN ignores START, next accept in the first IDLE cycle.
      sel = 1'b0; cell_tt = 16'h8000; n_done = 0;
      @(negedge CK); start = 1'b1;
      @(posedge CK);
      for (int e = 0; e <= 52; e++) begin
         if (e > 0) @(posedge CK);
         @(negedge CK);
         if (done_m === 1'b1) n_done++;
         if (e == 49) begin
            check("hold_start_idle_busy", {31'd0, busy_m}, 32'd0);
            check("hold_start_idle_pass", {31'd0, pass_m}, 32'd1);
         end
         if (e == 50) begin
            check("hold_start_reaccept_busy", {31'd0, busy_m}, 32'd1);
            check("hold_start_reaccept_pass", {31'd0, pass_m}, 32'd0);
         end
      end
      check("hold_start_done_count", n_done, 1);
      start = 1'b0;

      // Abort the second run mid-flight at A=7.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge CK);
         if (a_m === 4'd7) found = 1'b1;
      end
      check("reach_a7", {31'd0, found}, 32'd1);
      #2 RN = 1'b0;
      #1 check_all_zero("midrun_reset");
      @(negedge CK); RN = 1'b1;
      run(1'b0, 16'h8000, 11'b00000_0000_0_1, "restart_after_abort");

      // Randomised cell tables: fully random or a few flipped responses.
      for (int i = 0; i < 8; i++) begin
         logic        s;
         logic [15:0] ex, tt;
         s  = 1'($urandom_range(0, 1));
         ex = s ? 16'h7FFF : 16'h8000;
         if ($urandom_range(0, 1) == 0) tt = 16'($urandom);
         else tt = ex ^ (16'(1) << $urandom_range(0, 15)) ^ (16'($urandom_range(0, 1)) << $urandom_range(0, 15));
         run(s, tt, model(tt, ex), $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
